number_sequencer: RTL and testbench

Controller that sequences the 5-bit number detector: it owns the `num` bus feeding the detector, advances it automatically at a programmable rate or one step per button press, and loads it from switches. It watches the detector's LED pattern and auto-pauses when a selected flag fires. It sits between the board buttons/switches and the detector; `led_out` drives the board LEDs.

---
 rtl/number_sequencer.sv | 122 ++++++++++++
 tb/tb_number_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/number_sequencer.sv
// Sequencer for the 5-bit number detector: drives num by button step, timed run or switch load.
// Ports: clk, rst_n, run/step/load buttons, dir, sw, match_mask, led_in -> num, led_out, running, wrap.
module number_sequencer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       load_btn,
  input  logic       dir,
  input  logic [4:0] sw,
  input  logic [4:0] match_mask,
  input  logic [4:0] led_in,
  output logic [4:0] num,
  output logic [4:0] led_out,
  output logic       running,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state, state_d;

  logic [PW-1:0] presc, presc_d;
  logic [4:0]    num_d;
  logic [4:0]    nxt;
  logic          wrap_d;
  logic          adv_q, adv_d;

  // bit 0 run, bit 1 step, bit 2 load
  logic [2:0] btn;
  logic [2:0] s1, s2, prev;
  logic [2:0] pulse;

  logic run_p, step_p, load_p;
  logic tick, apause, adv;

  assign btn    = {load_btn, step_btn, run_btn};
  assign pulse  = s2 & ~prev;
  assign run_p  = pulse[0];
  assign step_p = pulse[1];
  assign load_p = pulse[2];

  assign tick   = (state == RUN) && (presc == TOP);
  assign apause = (state == RUN) && adv_q &&
                  (|(led_in & match_mask));
  assign adv    = ((state == PAUSE) && step_p) || tick;
  assign nxt    = dir ? num - 5'd1 : num + 5'd1;

  always_comb begin
    state_d = state;
    presc_d = presc;
    num_d   = num;
    wrap_d  = 1'b0;
    adv_d   = 1'b0;

    if (state == RUN) begin
      presc_d = tick ? '0 : presc + 1'b1;
    end

    // load wins over any advance on the same edge
    if (load_p) begin
      num_d   = sw;
      presc_d = '0;
    end else if (adv) begin
      num_d  = nxt;
      wrap_d = dir ? (num == 5'd0) : (num == 5'd31);
      adv_d  = tick;
    end

    // auto-pause swallows a coincident run pulse
    case (state)
      PAUSE: begin
        if (run_p) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (apause || run_p) begin
          state_d = PAUSE;
          presc_d = '0;
        end
      end
      default: state_d = PAUSE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      state   <= PAUSE;
      presc   <= '0;
      num     <= '0;
      wrap    <= 1'b0;
      adv_q   <= 1'b0;
      led_out <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      prev    <= s2;
      state   <= state_d;
      presc   <= presc_d;
      num     <= num_d;
      wrap    <= wrap_d;
      adv_q   <= adv_d;
      led_out <= led_in;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_number_sequencer.sv
// Scoreboard bench for number_sequencer with a small stand-in detector.
// Expectations are queued with a target cycle and checked on the falling edge.
module tb_number_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run_btn, step_btn, load_btn;
  logic       dir;
  logic [4:0] sw, match_mask, led_in;
  logic [4:0] num, led_out;
  logic       running, wrap;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int c, e;

  typedef struct {
    int at;
    int n;
    int r;
    int w;
    int led;
  } exp_t;

  exp_t  eq[$];
  string tq[$];

  function automatic logic [4:0] det(input logic [4:0] v);
    logic [4:0] l;
    l[0] = (v == 5'd31);
    l[1] = (v == 5'd16);
    l[2] = (v == 5'd20);
    l[3] = (v == 5'd3) || (v == 5'd11);
    l[4] = (v >= 5'd24);
    return l;
  endfunction

  assign led_in = det(num);

  number_sequencer #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .load_btn   (load_btn),
    .dir        (dir),
    .sw         (sw),
    .match_mask (match_mask),
    .led_in     (led_in),
    .num        (num),
    .led_out    (led_out),
    .running    (running),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_at(input int at, input int n, input int r,
                        input int w, input int led, input string tag);
    exp_t x;
    x.at = at; x.n = n; x.r = r; x.w = w; x.led = led;
    eq.push_back(x);
    tq.push_back(tag);
  endtask

  always @(negedge clk) begin
    for (int i = eq.size() - 1; i >= 0; i--) begin
      if (eq[i].at <= cyc) begin
        if (eq[i].at < cyc) chk({tq[i], ".late"}, cyc, eq[i].at);
        chk({tq[i], ".num"}, int'(num), eq[i].n);
        chk({tq[i], ".running"}, int'(running), eq[i].r);
        chk({tq[i], ".wrap"}, int'(wrap), eq[i].w);
        if (eq[i].led >= 0)
          chk({tq[i], ".led_out"}, int'(led_out), eq[i].led);
        eq.delete(i);
        tq.delete(i);
      end
    end
  end

  task automatic press(input int which, input int hold);
    case (which)
      0: run_btn = 1'b1;
      1: step_btn = 1'b1;
      default: load_btn = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    case (which)
      0: run_btn = 1'b0;
      1: step_btn = 1'b0;
      default: load_btn = 1'b0;
    endcase
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    run_btn = 0; step_btn = 0; load_btn = 0;
    dir = 0; sw = 0; match_mask = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_btn    = 1'($urandom % 2);
      step_btn   = 1'($urandom % 2);
      load_btn   = 1'($urandom % 2);
      dir        = 1'($urandom % 2);
      sw         = 5'($urandom);
      match_mask = 5'($urandom);
      exp_at(cyc + 1, 0, 0, 0, 0, "rst_hold");
      @(negedge clk);
    end
    run_btn = 0; step_btn = 0; load_btn = 0;
    dir = 0; sw = 0; match_mask = 0;
    rst_n = 1'b1;
    c = cyc;
    exp_at(c + 1, 0, 0, 0, 0, "rst_rel");
    exp_at(c + 4, 0, 0, 0, 0, "rst_idle");
    repeat (5) @(negedge clk);

    // step up, button held
    c = cyc;
    exp_at(c + 2, 0, 0, 0, -1, "step_lat");
    exp_at(c + 3, 1, 0, 0, -1, "step_up");
    exp_at(c + 4, 1, 0, 0, int'(det(5'd1)), "step_led");
    exp_at(c + 7, 1, 0, 0, -1, "step_hold");
    press(1, 4);
    repeat (4) @(negedge clk);

    // step down 1->0, then 0->31 wrap
    dir = 1'b1;
    c = cyc;
    exp_at(c + 3, 0, 0, 0, -1, "step_dn0");
    press(1, 2);
    repeat (2) @(negedge clk);
    c = cyc;
    exp_at(c + 3, 31, 0, 1, -1, "wrap_dn");
    exp_at(c + 4, 31, 0, 0, -1, "wrap_1cyc");
    press(1, 2);
    repeat (3) @(negedge clk);

    // load 28 in pause
    dir = 1'b0;
    sw = 5'd28;
    c = cyc;
    exp_at(c + 3, 28, 0, 0, -1, "load_pause");
    press(2, 2);
    repeat (3) @(negedge clk);

    // run cadence with wrap, then stop
    c = cyc;
    e = c + 3;
    exp_at(e,      28, 1, 0, -1, "run_entry");
    exp_at(e + 3,  28, 1, 0, -1, "run_pre");
    exp_at(e + 4,  29, 1, 0, -1, "run_t1");
    exp_at(e + 8,  30, 1, 0, -1, "run_t2");
    exp_at(e + 12, 31, 1, 0, -1, "run_t3");
    exp_at(e + 16,  0, 1, 1, -1, "run_wrap");
    exp_at(e + 17,  0, 1, 0, -1, "run_wrap_end");
    exp_at(e + 20,  1, 1, 0, -1, "run_t5");
    exp_at(e + 24,  2, 1, 0, -1, "run_t6");
    exp_at(e + 25,  2, 0, 0, -1, "run_stop");
    exp_at(e + 32,  2, 0, 0, -1, "run_frozen");
    press(0, 4);
    wait_to(e + 22);
    press(0, 4);
    wait_to(e + 33);

    // load landing on a tick edge, step ignored in run
    sw = 5'd17;
    c = cyc;
    e = c + 3;
    exp_at(e + 4,   3, 1, 0, -1, "lp_t1");
    exp_at(e + 8,  17, 1, 0, -1, "lp_load");
    exp_at(e + 11, 17, 1, 0, -1, "lp_hold");
    exp_at(e + 12, 18, 1, 0, -1, "lp_next");
    exp_at(e + 13, 18, 1, 0, -1, "lp_step_ign");
    exp_at(e + 16, 19, 1, 0, -1, "lp_t2");
    exp_at(e + 18, 19, 0, 0, -1, "lp_stop");
    exp_at(e + 22, 19, 0, 0, -1, "lp_frozen");
    press(0, 4);
    wait_to(e + 5);
    press(2, 4);
    wait_to(e + 10);
    press(1, 4);
    wait_to(e + 15);
    press(0, 4);
    wait_to(e + 23);

    // auto-pause on detector flag
    sw = 5'd0;
    match_mask = 5'b01000;
    c = cyc;
    exp_at(c + 3, 0, 0, 0, -1, "ap_load0");
    press(2, 4);
    wait_to(c + 6);
    c = cyc;
    e = c + 3;
    exp_at(e + 4,  1, 1, 0, -1, "ap_t1");
    exp_at(e + 8,  2, 1, 0, -1, "ap_t2");
    exp_at(e + 12, 3, 1, 0, -1, "ap_t3");
    exp_at(e + 13, 3, 0, 0, 8, "ap_pause");
    exp_at(e + 17, 3, 0, 0, -1, "ap_run_lost");
    exp_at(e + 22, 3, 0, 0, -1, "ap_frozen");
    press(0, 4);
    wait_to(e + 10);
    press(0, 4);
    wait_to(e + 23);

    // reset between edges while running
    match_mask = 5'd0;
    c = cyc;
    e = c + 3;
    exp_at(e,     3, 1, 0, -1, "rr_entry");
    exp_at(e + 4, 4, 1, 0, -1, "rr_adv");
    press(0, 4);
    wait_to(e + 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_async.num", int'(num), 0);
    chk("rr_async.running", int'(running), 0);
    chk("rr_async.wrap", int'(wrap), 0);
    chk("rr_async.led_out", int'(led_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    exp_at(c + 1, 0, 0, 0, -1, "rr_rel");
    exp_at(c + 8, 0, 0, 0, -1, "rr_pause");
    repeat (10) @(negedge clk);

    chk("leftover", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
